// File: rtl/mod_ctrl_pkg.sv
// Shared definitions for the iterative modulo/divide controller.
// State encodings are also used by the ALU decoder for MOD/DIV ops.
package mod_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_ctrl_if.sv
// Request/result bundle between the op decoder and the modulo controller.
// The master issues start with operands; the slave returns results.
interface mod_ctrl_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] quotient;
    logic             div_zero;

    modport master (
        output start, a_in, b_in,
        input  busy, done, remainder, quotient, div_zero
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, remainder, quotient, div_zero
    );

endinterface

// File: rtl/mod_step.sv
// One subtract-and-compare step: diff = r - bq, lt = (r < bq), unsigned.
// Subtraction is r + ~bq + 1 with the carry-out discarded.
module mod_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] bq,
    output logic [WIDTH-1:0] diff,
    output logic             lt
);

    assign diff = r + ~bq + {{(WIDTH-1){1'b0}}, 1'b1};
    assign lt   = (r < bq);

endmodule

// File: rtl/mod_ctrl.sv
// Iterative modulo controller: one subtraction per cycle until r < bq,
// then publishes remainder, quotient and divide-by-zero with a done pulse.
module mod_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    mod_ctrl_if.slave  bus
);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] bq;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] diff;
    logic             lt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             dz_q;

    logic load;
    logic step;
    logic fin;

    mod_step #(.WIDTH(WIDTH)) u_step (
        .r    (r),
        .bq   (bq),
        .diff (diff),
        .lt   (lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Zero divisor is tested before the compare so it never subtracts.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bq == '0 || lt) begin
                    fin      = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r     <= '0;
            bq    <= '0;
            q     <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            if (load) begin
                r  <= bus.a_in;
                bq <= bus.b_in;
                q  <= '0;
            end
            if (step) begin
                r <= diff;
                q <= q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
            if (fin) begin
                rem_q <= r;
                quo_q <= q;
                dz_q  <= (bq == '0);
            end
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.remainder = rem_q;
    assign bus.quotient  = quo_q;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_mod_ctrl.sv
// Directed bench for mod_ctrl: hand-computed results, latency and
// handshake behaviour including ignored starts and mid-run reset.
module tb_mod_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mod_ctrl_if #(.WIDTH(32)) bus ();

    mod_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, optionally pulse a second start mid-run,
    // and check latency (cycle q+2) and the held results.
    task automatic run(input string tag,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [31:0] eq,
                       input logic ez, input int ecyc,
                       input int ewait = -1, input int pulse_at = -1,
                       input logic [31:0] pa = 0,
                       input logic [31:0] pb = 0);
        int  n;
        int  w;
        bit  got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        w   = 0;
        got = 1'b0;
        while (!got && w < 8) begin
            @(posedge clk);
            #1;
            w++;
            if (bus.busy) got = 1'b1;
        end
        bus.start = 1'b0;
        chk({tag, "_accept"}, {63'd0, got}, 64'd1);
        if (ewait >= 0) chk({tag, "_wait"}, w, ewait);
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            if (n == pulse_at) begin
                bus.start = 1'b1;
                bus.a_in  = pa;
                bus.b_in  = pb;
            end
            @(posedge clk);
            #1;
            n++;
            bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        chk({tag, "_cycle"}, n + 1, ecyc);
        chk({tag, "_rem"}, bus.remainder, er);
        chk({tag, "_quo"}, bus.quotient, eq);
        chk({tag, "_dz"}, bus.div_zero, ez);
        chk({tag, "_busy"}, bus.busy, 1);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {bus.busy, bus.done}, 0);
        chk({tag, "_hold"}, bus.remainder, er);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rem", bus.remainder, 0);
        chk("rst_quo", bus.quotient, 0);
        chk("rst_dz", bus.div_zero, 0);
        rst_n = 1'b1;

        run("m100_7", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 16);
        run("m5_9", 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 2);
        run("bzero", 32'h1234, 32'd0, 32'h1234, 32'd0, 1'b1, 2);
        run("maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1,
            1'b0, 3, 1);
        run("b2b", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 2, 1);
        run("ignore", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 16,
            -1, 4, 32'd9, 32'd2);

        // Reset in the middle of a run drops the request.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 32'd100;
        bus.b_in  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("mid_busy", bus.busy, 1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_rem", bus.remainder, 0);
        chk("mid_rst_quo", bus.quotient, 0);
        chk("mid_rst_dz", bus.div_zero, 0);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("mid_no_done", bus.done, 0);
        end
        run("after_rst", 32'd23, 32'd5, 32'd3, 32'd4, 1'b0, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
